// File: rtl/iter_counter_pkg.sv
// iter_counter_pkg: shared FSM state type and direction/mode encodings for iter_counter
package iter_counter_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic DIR_DOWN     = 1'b0;
    localparam logic DIR_UP       = 1'b1;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;
endpackage

// File: rtl/iter_counter_step.sv
// iter_counter_step: combinational +/-1 step (modulo 2^DW) and terminal-value compare
module iter_counter_step
    import iter_counter_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] cur,
    input  logic [DW-1:0] limit,
    input  logic          dir,
    output logic [DW-1:0] nxt,
    output logic          at_limit
);
    assign nxt      = (dir == DIR_UP) ? cur + DW'(1) : cur - DW'(1);
    assign at_limit = (cur == limit);
endmodule

// File: rtl/iter_counter.sv
// iter_counter: loadable up/down iteration counter with start/busy/done handshake and one-shot/auto-reload.
// Optional ITER_COUNTER_ABORT_EN adds an abort input that drops a running pass back to IDLE.
module iter_counter
    import iter_counter_pkg::*;
#(
    parameter int          DW   = 8,
    parameter logic [DW-1:0] INIT = DW'(7)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] load_val,
    input  logic [DW-1:0] limit,
    input  logic          dir,
    input  logic          mode,
    input  logic          ena,
`ifdef ITER_COUNTER_ABORT_EN
    input  logic          abort,
`endif
    output logic [DW-1:0] result,
    output logic          busy,
    output logic          done,
    output logic          tc
);
    state_t        state, state_d;
    logic [DW-1:0] result_d, load_q, load_d, limit_q, limit_d, nxt;
    logic          dir_q, dir_d, mode_q, mode_d, tc_d, at_limit, abort_hit;

    iter_counter_step #(.DW(DW)) u_step (
        .cur     (result),
        .limit   (limit_q),
        .dir     (dir_q),
        .nxt     (nxt),
        .at_limit(at_limit)
    );

`ifdef ITER_COUNTER_ABORT_EN
    assign abort_hit = abort && (state == RUN);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state;
        result_d = result;
        load_d   = load_q;
        limit_d  = limit_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;
        if (abort_hit) begin
            state_d = IDLE;
        end else if (start) begin
            state_d  = RUN;
            result_d = load_val;
            load_d   = load_val;
            limit_d  = limit;
            dir_d    = dir;
            mode_d   = mode;
        end else if (state == RUN && ena) begin
            tc_d     = at_limit;
            // terminal: one-shot parks on limit, reload restarts from the latched load
            result_d = !at_limit ? nxt : (mode_q == MODE_RELOAD) ? load_q : result;
            state_d  = (at_limit && mode_q == MODE_ONESHOT) ? DONE : RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            result  <= INIT;
            load_q  <= INIT;
            limit_q <= '0;
            dir_q   <= DIR_DOWN;
            mode_q  <= MODE_ONESHOT;
            tc      <= 1'b0;
        end else begin
            state   <= state_d;
            result  <= result_d;
            load_q  <= load_d;
            limit_q <= limit_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            tc      <= tc_d;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_iter_counter.sv
// tb_iter_counter: randomized + directed scoreboard bench for iter_counter (pass-progress reference model)
module tb_iter_counter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, dir = 1'b0, mode = 1'b0, ena = 1'b0;
    logic [7:0] load_val = '0, limit = '0;
    logic [7:0] result;
    logic       busy, done, tc;
`ifdef ITER_COUNTER_ABORT_EN
    logic       abort = 1'b0;
`endif

    iter_counter dut (
        .clk(clk), .reset(reset), .start(start), .load_val(load_val), .limit(limit),
        .dir(dir), .mode(mode), .ena(ena),
`ifdef ITER_COUNTER_ABORT_EN
        .abort(abort),
`endif
        .result(result), .busy(busy), .done(done), .tc(tc)
    );

    always #5 clk = ~clk;

    typedef struct {int res; int busy; int done; int tc;} exp_t;
    exp_t q[$];
    int checks = 0, passed = 0;

    // model: a pass is (load, direction, length); progress is the number of steps taken
    int m_load, m_lim, m_len, m_taken, m_ph;
    bit m_dir, m_mode;

    function automatic int m_res();
        return m_dir ? (m_load + m_taken) % 256 : (m_load - m_taken + 256) % 256;
    endfunction

    task automatic m_reset();
        m_load = 7; m_lim = 0; m_dir = 0; m_mode = 0; m_taken = 0; m_len = 8; m_ph = 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input bit st, input int lv, input int lim, input bit d, input bit md,
                        input bit e, input bit ab = 1'b0);
        exp_t x;
        bit   t = 1'b0;
        @(negedge clk);
        start = st; load_val = 8'(lv); limit = 8'(lim); dir = d; mode = md; ena = e;
`ifdef ITER_COUNTER_ABORT_EN
        abort = ab;
`endif
`ifdef ITER_COUNTER_ABORT_EN
        if (ab && m_ph == 1) m_ph = 0;
        else
`endif
        if (st) begin
            m_load = lv; m_lim = lim; m_dir = d; m_mode = md; m_taken = 0; m_ph = 1;
            m_len = (d ? (lim - lv + 256) % 256 : (lv - lim + 256) % 256) + 1;
        end else if (m_ph == 1 && e) begin
            if (m_taken == m_len - 1) begin
                t = 1'b1;
                if (m_mode) m_taken = 0;
                else m_ph = 2;
            end else m_taken++;
        end
        x.res = m_res(); x.busy = int'(m_ph == 1); x.done = int'(m_ph == 2); x.tc = int'(t);
        q.push_back(x);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            check("result", int'(result), x.res);
            check("busy", int'(busy), x.busy);
            check("done", int'(done), x.done);
            check("tc", int'(tc), x.tc);
        end
    end

    task automatic check_reset_vals();
        check("rst_result", int'(result), 7);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_tc", int'(tc), 0);
    endtask

    initial begin
        m_reset();
        #12;
        check_reset_vals();
        @(negedge clk) reset = 1'b1;
        step(0, 0, 0, 0, 0, 1);
        // down, one-shot 7..0
        step(1, 7, 0, 0, 0, 0);
        repeat (8) step(0, 0, 0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0, 1);
        // up with wrap 254,255,0,1
        step(1, 254, 1, 1, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0, 1);
        // auto-reload 3..0
        step(1, 3, 0, 0, 1, 0);
        repeat (12) step(0, 0, 0, 0, 0, 1);
        // reload with load==limit: tc every cycle
        step(1, 9, 9, 1, 1, 0);
        repeat (4) step(0, 0, 0, 0, 0, 1);
        // gaps and restart
        step(1, 10, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, bit'(i % 2));
        step(1, 5, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(1, 5, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // start while DONE, and ena ignored in DONE
        step(1, 1, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 1);
        step(1, 100, 102, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 1);
`ifdef ITER_COUNTER_ABORT_EN
        step(1, 10, 0, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        step(1, 20, 0, 0, 0, 0);
        step(1, 30, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1);
`endif
        for (int i = 0; i < 500; i++) begin
            bit d = bit'($urandom_range(0, 1));
            int lv = int'($urandom_range(0, 255));
            int k = int'($urandom_range(0, 6));
            int lim = d ? (lv + k) % 256 : (lv - k + 256) % 256;
            step(bit'($urandom_range(0, 15) == 0), lv, lim, d, bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 31) == 0));
        end
        // reset mid-pass: outputs return immediately, no edge
        step(1, 20, 10, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check_reset_vals();
        m_reset();
        @(negedge clk) reset = 1'b1;
        repeat (2) step(0, 0, 0, 0, 0, 1);
        step(1, 0, 255, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 1);
        repeat (3) @(posedge clk);
        #3;
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
